// File: rtl/fma_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// fma_stream_ctrl_if
// Stream bundle for fma_stream_ctrl: the operand-triple input stream and the
// result output stream, both valid/ready.
//   in_valid/in_ready     operand triple handshake
//   in_a/in_b/in_c        FP32 operands (result = a*b + c)
//   in_tag                user tag carried with the operation
//   out_valid/out_ready   result handshake
//   out_result/out_tag    FP32 result and its tag
//   out_special           out_result is Inf/NaN (exponent all ones)
// Modports: slave = the adapter, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface fma_stream_ctrl_if #(
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_special;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_special
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_special
  );
endinterface

// File: rtl/fma_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fma_stream_ctrl
// Valid/ready adapter around a non-stallable FP32 FMA core of fixed latency.
// Operands go straight to the core; a {vld, tag} delay line matched to the core
// latency marks which core outputs belong to accepted operations, and those are
// captured into a show-ahead output FIFO. Credits (in-flight ops + buffered
// results never exceed FIFO_DEPTH) guarantee a capture always finds space.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous discard of everything in flight and buffered
//   s               stream bundle (slave modport), see fma_stream_ctrl_if
//   fma_a/b/c       operands to the core (combinational copy of in_a/b/c)
//   fma_result      core result, FMA_LAT edges after the operands
//   occupancy       registered in-flight + buffered count
// -----------------------------------------------------------------------------
module fma_stream_ctrl #(
  parameter int FMA_LAT    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  fma_stream_ctrl_if.slave              s,
  output logic [31:0]                   fma_a,
  output logic [31:0]                   fma_b,
  output logic [31:0]                   fma_c,
  input  logic [31:0]                   fma_result,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Inf/NaN decode: exponent field all ones.
  function automatic logic is_special(input logic [31:0] v);
    return (v[30:23] == 8'hFF);
  endfunction

  // Delay line tracking accepted ops through the core.
  logic [FMA_LAT-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   dtag_q [FMA_LAT];
  logic [TAG_W-1:0]   dtag_d [FMA_LAT];

  // Output FIFO storage and control.
  logic [31:0]        mem_res_q [FIFO_DEPTH];
  logic [31:0]        mem_res_d [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]   infl_cnt_q, infl_cnt_d;
  logic [CNT_W-1:0]   occ_q, occ_d;

  // Registered output head.
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_special_q, out_special_d;

  logic               in_ready;
  logic               issue;
  logic               push;
  logic               pop;

  // Handshake decode and next-state computation for all tracked state.
  always_comb begin
    // occ_q always equals fifo_cnt_q + infl_cnt_q, so it serves as the credit count.
    in_ready = !flush && (occ_q < DEPTH_C);
    issue    = s.in_valid && in_ready;
    push     = vld_q[FMA_LAT-1] && !flush;
    pop      = (fifo_cnt_q != {CNT_W{1'b0}}) && s.out_ready && !flush;

    // Delay line: tag only loaded for real issues so idle operand buses are ignored.
    dtag_d[0] = issue ? s.in_tag : {TAG_W{1'b0}};
    for (int i = 1; i < FMA_LAT; i++) begin
      dtag_d[i] = dtag_q[i-1];
    end

    // FIFO write: the core output paired with the op leaving the last stage.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_res_d[i] = (push && (wr_ptr_q == PTR_W'(i))) ? fma_result : mem_res_q[i];
      mem_tag_d[i] = (push && (wr_ptr_q == PTR_W'(i))) ? dtag_q[FMA_LAT-1] : mem_tag_q[i];
    end

    if (flush) begin
      vld_d      = {FMA_LAT{1'b0}};
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      fifo_cnt_d = {CNT_W{1'b0}};
      infl_cnt_d = {CNT_W{1'b0}};
    end else begin
      vld_d      = {vld_q[FMA_LAT-2:0], issue};
      wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      infl_cnt_d = infl_cnt_q + CNT_W'(issue) - CNT_W'(push);
    end

    occ_d       = fifo_cnt_d + infl_cnt_d;
    out_valid_d = (fifo_cnt_d != {CNT_W{1'b0}});

    // Next head: if the entry being written lands exactly at the next read slot
    // (FIFO empty after this cycle's pop), take it from the write data since the
    // memory has not been updated yet. Credits rule out the "full, no pop" alias.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      out_result_d = fma_result;
      out_tag_d    = dtag_q[FMA_LAT-1];
    end else begin
      out_result_d = mem_res_q[rd_ptr_d];
      out_tag_d    = mem_tag_q[rd_ptr_d];
    end
    out_special_d = is_special(out_result_d);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q         <= {FMA_LAT{1'b0}};
      for (int i = 0; i < FMA_LAT; i++) begin
        dtag_q[i] <= {TAG_W{1'b0}};
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_res_q[i] <= 32'h0000_0000;
        mem_tag_q[i] <= {TAG_W{1'b0}};
      end
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      fifo_cnt_q    <= {CNT_W{1'b0}};
      infl_cnt_q    <= {CNT_W{1'b0}};
      occ_q         <= {CNT_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'h0000_0000;
      out_tag_q     <= {TAG_W{1'b0}};
      out_special_q <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      dtag_q        <= dtag_d;
      mem_res_q     <= mem_res_d;
      mem_tag_q     <= mem_tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      infl_cnt_q    <= infl_cnt_d;
      occ_q         <= occ_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_special_q <= out_special_d;
    end
  end

  assign fma_a         = s.in_a;
  assign fma_b         = s.in_b;
  assign fma_c         = s.in_c;
  assign s.in_ready    = in_ready;
  assign s.out_valid   = out_valid_q;
  assign s.out_result  = out_result_q;
  assign s.out_tag     = out_tag_q;
  assign s.out_special = out_special_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_fma_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fma_stream_ctrl
// Directed bench for fma_stream_ctrl with a 5-stage core model. The core model
// returns the true FMA for the two FP vectors used explicitly and a bit-mix of
// the operands otherwise; the adapter passes results through untouched, so any
// deterministic function distinguishes ops.
// -----------------------------------------------------------------------------
module tb_fma_stream_ctrl;
  localparam int FMA_LAT    = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] fma_a, fma_b, fma_c, fma_result;
  logic [3:0]  occupancy;
  logic [31:0] pipe [FMA_LAT];

  int n_cmp = 0;
  int n_err = 0;
  int sent_n, recv_n, cyc_n, first_rx, last_rx, ready_drops;
  logic seen;

  fma_stream_ctrl_if #(.TAG_W(TAG_W)) sif ();

  fma_stream_ctrl #(.FMA_LAT(FMA_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .s(sif),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4040_0000) return 32'h40A0_0000;
    else if (a == 32'h7F80_0000 && b == 32'h3F80_0000 && c == 32'h0000_0000) return 32'h7F80_0000;
    else return a ^ {b[15:0], b[31:16]} ^ c;
  endfunction

  // Core model: result appears FMA_LAT edges after operands are sampled.
  always @(posedge clk) begin
    pipe[0] <= core_fn(fma_a, fma_b, fma_c);
    for (int i = 1; i < FMA_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fma_result = pipe[FMA_LAT-1];

  function automatic logic [31:0] op_a(input int seq);
    return 32'h4000_0000 + 32'(seq) * 32'h0001_0101;
  endfunction
  function automatic logic [31:0] op_b(input int seq);
    return 32'h3F00_0000 ^ (32'(seq) << 4);
  endfunction
  function automatic logic [31:0] op_c(input int seq);
    return 32'hC000_0000 | 32'(seq);
  endfunction
  function automatic logic [31:0] exp_res(input int seq);
    return core_fn(op_a(seq), op_b(seq), op_c(seq));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drive_seq(input int seq);
    sif.in_a   = op_a(seq);
    sif.in_b   = op_b(seq);
    sif.in_c   = op_c(seq);
    sif.in_tag = 4'(seq);
  endtask

  // Offer ops sent_n.. up to limit; check every transferred output beat in order.
  task automatic stream(input int ncyc, input int limit);
    logic iss;
    logic [3:0] etag;
    for (int k = 0; k < ncyc; k++) begin
      sif.in_valid = (sent_n < limit);
      drive_seq(sent_n);
      iss = sif.in_valid && sif.in_ready;
      if (sif.in_valid && !sif.in_ready) ready_drops++;
      if (sif.out_valid && sif.out_ready) begin
        etag = 4'(recv_n);
        check("beat_tag", {28'h0, sif.out_tag}, {28'h0, etag});
        check("beat_result", sif.out_result, exp_res(recv_n));
        if (first_rx < 0) first_rx = cyc_n;
        last_rx = cyc_n;
        recv_n++;
      end
      tick();
      if (iss) sent_n++;
    end
    sif.in_valid = 1'b0;
  endtask

  initial begin
    sif.in_valid = 1'b0; sif.out_ready = 1'b0;
    sif.in_a = 32'h0; sif.in_b = 32'h0; sif.in_c = 32'h0; sif.in_tag = 4'h0;
    sent_n = 0; recv_n = 0; cyc_n = 0; first_rx = -1; last_rx = 0; ready_drops = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_result", sif.out_result, 32'h0);
    check("rst_out_tag", 32'(sif.out_tag), 32'd0);
    check("rst_out_special", 32'(sif.out_special), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(sif.in_ready), 32'd1);

    // 1. Single op, 6 clocks issue->out_valid
    sif.out_ready = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_a = 32'h3F80_0000; sif.in_b = 32'h4000_0000; sif.in_c = 32'h4040_0000; sif.in_tag = 4'd5;
    check("t1_in_ready", 32'(sif.in_ready), 32'd1);
    tick();
    sif.in_valid = 1'b0;
    seen = sif.out_valid;
    repeat (4) begin tick(); seen = seen | sif.out_valid; end
    check("t1_no_early_valid", 32'(seen), 32'd0);
    tick();
    check("t1_out_valid", 32'(sif.out_valid), 32'd1);
    check("t1_result", sif.out_result, 32'h40A0_0000);
    check("t1_tag", 32'(sif.out_tag), 32'd5);
    check("t1_special", 32'(sif.out_special), 32'd0);
    check("t1_occupancy", 32'(occupancy), 32'd1);
    tick();
    check("t1_one_beat", 32'(sif.out_valid), 32'd0);
    check("t1_occ_empty", 32'(occupancy), 32'd0);

    // 2. 16 back-to-back ops, FIFO at one entry with push+pop each cycle
    sent_n = 0; recv_n = 0; ready_drops = 0; first_rx = -1;
    stream(10, 16);
    check("t2_steady_occ", 32'(occupancy), 32'd6);
    stream(14, 16);
    check("t2_ready_drops", 32'(ready_drops), 32'd0);
    check("t2_recv_count", 32'(recv_n), 32'd16);
    check("t2_one_per_clk", 32'(last_rx - first_rx), 32'd15);

    // 3. Backpressure: 20 offered, exactly 8 accepted
    sif.out_ready = 1'b0;
    stream(20, 36);
    check("t3_accepted", 32'(sent_n - 16), 32'd8);
    check("t3_in_ready", 32'(sif.in_ready), 32'd0);
    check("t3_occupancy", 32'(occupancy), 32'd8);
    check("t3_out_valid", 32'(sif.out_valid), 32'd1);
    check("t3_hold_tag", 32'(sif.out_tag), 32'd0);
    tick();
    check("t3_hold_result", sif.out_result, exp_res(16));
    sif.out_ready = 1'b1;
    stream(20, 28);
    check("t3_recv_count", 32'(recv_n), 32'd28);
    check("t3_drained", 32'(occupancy), 32'd0);

    // 4. Full credit (3 buffered + 5 in flight): push and pop on the same edge
    sif.out_ready = 1'b0;
    stream(8, 36);
    check("t4_occ_full", 32'(occupancy), 32'd8);
    check("t4_head_tag", 32'(sif.out_tag), 32'd12);
    sif.out_ready = 1'b1;
    stream(1, 36);
    check("t4_occ_after", 32'(occupancy), 32'd7);
    check("t4_valid_after", 32'(sif.out_valid), 32'd1);
    check("t4_next_tag", 32'(sif.out_tag), 32'd13);
    stream(12, 36);
    check("t4_recv_count", 32'(recv_n), 32'd36);
    check("t4_drained", 32'(occupancy), 32'd0);

    // 5. Flush with 4 buffered and 3 in flight
    sif.out_ready = 1'b0;
    stream(7, 43);
    tick(); tick();
    check("t5_occ_before", 32'(occupancy), 32'd7);
    flush = 1'b1;
    sif.in_valid = 1'b1;
    drive_seq(sent_n);
    #1;
    check("t5_ready_in_flush", 32'(sif.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    sif.in_valid = 1'b0;
    #1;
    check("t5_out_valid", 32'(sif.out_valid), 32'd0);
    check("t5_occupancy", 32'(occupancy), 32'd0);
    check("t5_in_ready", 32'(sif.in_ready), 32'd1);
    sif.out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin tick(); seen = seen | sif.out_valid; end
    check("t5_no_stale", 32'(seen), 32'd0);
    check("t5_occ_after", 32'(occupancy), 32'd0);
    recv_n = sent_n;

    // 6. Inf result, then async reset mid-stream
    sif.out_ready = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_a = 32'h7F80_0000; sif.in_b = 32'h3F80_0000; sif.in_c = 32'h0000_0000; sif.in_tag = 4'd9;
    tick();
    sif.in_valid = 1'b0;
    repeat (6) tick();
    check("t6_valid", 32'(sif.out_valid), 32'd1);
    check("t6_special", 32'(sif.out_special), 32'd1);
    check("t6_result", sif.out_result, 32'h7F80_0000);
    check("t6_tag", 32'(sif.out_tag), 32'd9);
    stream(2, sent_n + 2);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(sif.out_valid), 32'd0);
    check("t6_rst_occ", 32'(occupancy), 32'd0);
    check("t6_rst_special", 32'(sif.out_special), 32'd0);
    #2;
    rst = 1'b0;
    sif.out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | sif.out_valid; end
    check("t6_no_partial", 32'(seen), 32'd0);

    // Recovery after reset
    sif.in_valid = 1'b1;
    sif.in_a = 32'h3F80_0000; sif.in_b = 32'h4000_0000; sif.in_c = 32'h4040_0000; sif.in_tag = 4'd3;
    tick();
    sif.in_valid = 1'b0;
    repeat (5) tick();
    check("post_rst_valid", 32'(sif.out_valid), 32'd1);
    check("post_rst_result", sif.out_result, 32'h40A0_0000);
    check("post_rst_tag", 32'(sif.out_tag), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
